alu_exec: RTL and testbench

ALU_EXEC -- requirements
Module: alu_exec

---
 rtl/alu_exec.sv | 207 ++++++++++++++++++++
 tb/tb_alu_exec.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_exec.sv
// ---------------------------------------------------------------------------
// alu_exec -- 8-bit execute unit with valid/ready handshakes on both sides.
//
// One-hot op select (active[n] selects op n):
//   0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOT a, 6 SHL, 7 SHR, 8 ASR, 9 MUL,
//   10 INC, 11 DEC, 12 CMP, 13 PASS a, 14 PASS b, 15 NOP.
// Any select pattern that is not exactly one-hot returns result 0 with err.
//
// Build option: define ALU_MUL_EN to include the iterative 8x8 shift-add
// multiplier (BUSY state, 9-cycle latency). Without it, MUL is illegal and
// all BUSY logic is compiled out.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   active     [15:0] one-hot op select, sampled on input transfer
//   a, b       [7:0]  operands, sampled on input transfer
//   in_valid   input-side valid
//   in_ready   input-side ready (IDLE, or DONE with out_ready high)
//   result     [15:0] zero-extended result (full product for MUL)
//   flags      [3:0]  {err, ovf, carry, zero}
//   out_valid  output-side valid (DONE)
//   out_ready  output-side ready
// ---------------------------------------------------------------------------
module alu_exec (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] active,
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [15:0] result,
    output logic [3:0]  flags,
    output logic        out_valid,
    input  logic        out_ready
);

    localparam int DATA_W = 8;

`ifdef ALU_MUL_EN
    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, DONE = 2'd2} state_t;
`endif

    state_t state, state_d, accept_state;

    function automatic logic is_onehot(input logic [15:0] v);
        return (v != '0) && ((v & (v - 16'd1)) == '0);
    endfunction

    logic                     sel_onehot;
    logic                     legal;
    logic                     is_mul;
    logic                     in_xfer;
    logic [3:0]               op_idx;
    logic signed [DATA_W-1:0] a_s;
    logic [DATA_W:0]          sum_x, dif_x, inc_x, dec_x;
    logic                     add_ovf, sub_ovf;
    logic [DATA_W-1:0]        res8;
    logic                     is_cmp;
    logic                     alu_err, alu_ovf, alu_carry, alu_zero;

    assign a_s     = a;
    assign sum_x   = {1'b0, a} + {1'b0, b};
    assign dif_x   = {1'b0, a} - {1'b0, b};
    assign inc_x   = {1'b0, a} + 9'd1;
    assign dec_x   = {1'b0, a} - 9'd1;
    // Signed overflow: operands agree (ADD) / differ (SUB) in sign and the
    // result sign differs from a.
    assign add_ovf = (a[7] == b[7]) && (sum_x[7] != a[7]);
    assign sub_ovf = (a[7] != b[7]) && (dif_x[7] != a[7]);

    assign sel_onehot = is_onehot(active);
`ifdef ALU_MUL_EN
    assign legal        = sel_onehot;
    assign is_mul       = sel_onehot & active[9];
    assign accept_state = is_mul ? BUSY : DONE;
`else
    // Without the multiplier a MUL select is simply another illegal pattern.
    assign legal        = sel_onehot & ~active[9];
    assign is_mul       = 1'b0;
    assign accept_state = DONE;
`endif

    always_comb begin
        op_idx = '0;
        for (int i = 0; i < 16; i++) begin
            if (active[i]) op_idx = i[3:0];
        end
    end

    // Single-cycle ALU evaluated on the live inputs; captured only on transfer.
    always_comb begin
        res8      = '0;
        is_cmp    = 1'b0;
        alu_err   = 1'b0;
        alu_ovf   = 1'b0;
        alu_carry = 1'b0;
        alu_zero  = 1'b0;
        if (!legal) begin
            alu_err = 1'b1;
        end else begin
            case (op_idx)
                4'd0:  begin res8 = sum_x[7:0]; alu_carry = sum_x[8]; alu_ovf = add_ovf; end
                4'd1:  begin res8 = dif_x[7:0]; alu_carry = dif_x[8]; alu_ovf = sub_ovf; end
                4'd2:  res8 = a & b;
                4'd3:  res8 = a | b;
                4'd4:  res8 = a ^ b;
                4'd5:  res8 = ~a;
                4'd6:  res8 = a << b[2:0];
                4'd7:  res8 = a >> b[2:0];
                4'd8:  res8 = a_s >>> b[2:0];
                4'd10: begin res8 = inc_x[7:0]; alu_carry = inc_x[8]; alu_ovf = ~a[7] & inc_x[7]; end
                4'd11: begin res8 = dec_x[7:0]; alu_carry = dec_x[8]; alu_ovf = a[7] & ~dec_x[7]; end
                4'd12: begin is_cmp = 1'b1; alu_carry = dif_x[8]; alu_ovf = sub_ovf; end
                4'd13: res8 = a;
                4'd14: res8 = b;
                default: res8 = '0;
            endcase
        end
        if (alu_err)     alu_zero = 1'b0;
        else if (is_cmp) alu_zero = (a == b);
        else             alu_zero = (res8 == '0);
    end

`ifdef ALU_MUL_EN
    logic [15:0] mcand;
    logic [7:0]  mplier;
    logic [15:0] acc, acc_next;
    logic [2:0]  cnt;
    logic        mul_last;

    assign acc_next = acc + (mplier[0] ? mcand : 16'h0000);
    assign mul_last = (state == BUSY) && (cnt == 3'd7);
`endif

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_d;
    end

    // FSM next-state and handshake outputs
    always_comb begin
        state_d   = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_d = accept_state;
            end
`ifdef ALU_MUL_EN
            BUSY: begin
                if (mul_last) state_d = DONE;
            end
`endif
            DONE: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
                if (out_ready) state_d = in_valid ? accept_state : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_xfer = in_valid & in_ready;

    // Result/flag registers and multiplier iteration state
    always_ff @(posedge clk) begin
        if (rst) begin
            result <= '0;
            flags  <= '0;
`ifdef ALU_MUL_EN
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
`endif
        end else begin
            if (in_xfer && !is_mul) begin
                result <= {8'h00, res8};
                flags  <= {alu_err, alu_ovf, alu_carry, alu_zero};
            end
`ifdef ALU_MUL_EN
            if (in_xfer && is_mul) begin
                mcand  <= {8'h00, a};
                mplier <= b;
                acc    <= '0;
                cnt    <= '0;
            end else if (state == BUSY) begin
                acc    <= acc_next;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                cnt    <= cnt + 3'd1;
                if (mul_last) begin
                    result <= acc_next;
                    flags  <= {3'b000, (acc_next == 16'h0000)};
                end
            end
`endif
        end
    end

endmodule

// File: tb/tb_alu_exec.sv
`timescale 1ns/1ps
module tb_alu_exec;

    logic        clk;
    logic        rst;
    logic [15:0] active;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] result;
    logic [3:0]  flags;
    logic        out_valid;
    logic        out_ready;

    int nvec = 0;
    int nerr = 0;

`ifdef ALU_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    alu_exec dut (
        .clk      (clk),
        .rst      (rst),
        .active   (active),
        .a        (a),
        .b        (b),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .result   (result),
        .flags    (flags),
        .out_valid(out_valid),
        .out_ready(out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: plain integer arithmetic on the op definitions.
    function automatic void model(input logic [15:0] act, input logic [7:0] x, input logic [7:0] y,
                                  output logic [15:0] r, output logic [3:0] f, output int lat);
        int ux, uy, sx, sy, s, t, idx, sh;
        bit c, v, z, e, cmp;
        ux = int'(x);
        uy = int'(y);
        sx = (ux >= 128) ? ux - 256 : ux;
        sy = (uy >= 128) ? uy - 256 : uy;
        sh = uy % 8;
        t = 0; c = 0; v = 0; e = 0; cmp = 0; lat = 1; idx = 0;
        if ($countones(act) != 1) begin
            e = 1;
        end else begin
            for (int i = 0; i < 16; i++) if (act[i]) idx = i;
            case (idx)
                0:  begin t = ux + uy; c = (t > 255); s = sx + sy; v = (s > 127) || (s < -128); end
                1:  begin t = ux - uy; c = (ux < uy); s = sx - sy; v = (s > 127) || (s < -128); end
                2:  t = ux & uy;
                3:  t = ux | uy;
                4:  t = ux ^ uy;
                5:  t = 255 - ux;
                6:  t = ux << sh;
                7:  t = ux >> sh;
                8:  t = sx >>> sh;
`ifdef ALU_MUL_EN
                9:  begin t = ux * uy; lat = 9; end
`else
                9:  e = 1;
`endif
                10: begin t = ux + 1; c = (t > 255); v = (sx + 1 > 127); end
                11: begin t = ux - 1; c = (ux < 1); v = (sx - 1 < -128); end
                12: begin cmp = 1; t = 0; c = (ux < uy); s = sx - sy; v = (s > 127) || (s < -128); end
                13: t = ux;
                14: t = uy;
                default: t = 0;
            endcase
        end
        if (e) begin t = 0; c = 0; v = 0; end
        if (idx != 9) t = t & 255;
        z = e ? 1'b0 : (cmp ? (ux == uy) : (t == 0));
        r = 16'(t);
        f = {e, v, c, z};
    endfunction

    function automatic logic [15:0] gen_act(input bit allow_mul);
        logic [15:0] v;
        int k;
        if ($urandom_range(0, 4) == 0) begin
            v = 16'($urandom);
        end else begin
            k = $urandom_range(0, 15);
            v = 16'h0001 << k;
        end
        if (!allow_mul && MUL_EN) v[9] = 1'b0;
        return v;
    endfunction

    // Issue one op from IDLE with out_ready high, scramble inputs afterwards,
    // wait (bounded) for out_valid and return latency/result/flags.
    task automatic run_op(input logic [15:0] act, input logic [7:0] x, input logic [7:0] y,
                          output int lat, output logic [15:0] r, output logic [3:0] f);
        out_ready = 1'b1;
        active = act; a = x; b = y; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        active = 16'($urandom); a = 8'($urandom); b = 8'($urandom);
        lat = 1;
        while (!out_valid && lat < 30) begin
            tick();
            lat++;
        end
        if (!out_valid) lat = -1;
        r = result;
        f = flags;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b1; active = 16'h0001; a = 8'hFF; b = 8'h01; out_ready = 1'b1;
        repeat (3) tick();
        rst = 1'b0; in_valid = 1'b0;
        nvec++;
        if (out_valid !== 1'b0 || result !== 16'h0000 || flags !== 4'h0 || in_ready !== 1'b1) begin
            nerr++;
            $display("FAIL reset_state: got ov=%0b res=%h fl=%b rdy=%0b, want ov=0 res=0000 fl=0000 rdy=1",
                     out_valid, result, flags, in_ready);
        end
        tick();
        nvec++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            nerr++;
            $display("FAIL reset_idle: got ov=%0b rdy=%0b, want ov=0 rdy=1", out_valid, in_ready);
        end
    endtask

    task automatic test_directed();
        logic [15:0] t_act [5] = '{16'h0001, 16'h0002, 16'h1000, 16'h0003, 16'h0000};
        logic [7:0]  t_a   [5] = '{8'hFF, 8'h80, 8'h05, 8'h12, 8'h34};
        logic [7:0]  t_b   [5] = '{8'h01, 8'h01, 8'h05, 8'h56, 8'h78};
        logic [15:0] t_r   [5] = '{16'h0000, 16'h007F, 16'h0000, 16'h0000, 16'h0000};
        logic [3:0]  t_f   [5] = '{4'b0011, 4'b0100, 4'b0001, 4'b1000, 4'b1000};
        int l;
        logic [15:0] r;
        logic [3:0]  f;
        for (int i = 0; i < 5; i++) begin
            run_op(t_act[i], t_a[i], t_b[i], l, r, f);
            nvec++;
            if (l != 1 || r !== t_r[i] || f !== t_f[i]) begin
                nerr++;
                $display("FAIL directed_%0d act=%h: got lat=%0d res=%h fl=%b, want lat=1 res=%h fl=%b",
                         i, t_act[i], l, r, f, t_r[i], t_f[i]);
            end
        end
    endtask

    task automatic test_mul();
`ifdef ALU_MUL_EN
        out_ready = 1'b1;
        active = 16'h0200; a = 8'hFF; b = 8'hFF; in_valid = 1'b1;
        tick();
        in_valid = 1'b0; a = 8'h00; b = 8'h00;
        for (int k = 1; k <= 8; k++) begin
            nvec++;
            if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
                nerr++;
                $display("FAIL mul_busy_cycle_%0d: got rdy=%0b ov=%0b, want rdy=0 ov=0", k, in_ready, out_valid);
            end
            if (k == 3) begin in_valid = 1'b1; active = 16'h0001; a = 8'h01; b = 8'h01; end
            if (k == 4) in_valid = 1'b0;
            tick();
        end
        nvec++;
        if (out_valid !== 1'b1 || result !== 16'hFE01 || flags !== 4'b0000) begin
            nerr++;
            $display("FAIL mul_ff_ff: got ov=%0b res=%h fl=%b, want ov=1 res=fe01 fl=0000", out_valid, result, flags);
        end
        tick();
`else
        int l;
        logic [15:0] r;
        logic [3:0]  f;
        run_op(16'h0200, 8'hFF, 8'hFF, l, r, f);
        nvec++;
        if (l != 1 || r !== 16'h0000 || f !== 4'b1000) begin
            nerr++;
            $display("FAIL mul_disabled: got lat=%0d res=%h fl=%b, want lat=1 res=0000 fl=1000", l, r, f);
        end
`endif
    endtask

    task automatic test_random();
        int l, el;
        logic [15:0] r, er, act;
        logic [3:0]  f, ef;
        logic [7:0]  x, y;
        for (int n = 0; n < 150; n++) begin
            act = gen_act(1'b1); x = 8'($urandom); y = 8'($urandom);
            model(act, x, y, er, ef, el);
            run_op(act, x, y, l, r, f);
            nvec++;
            if (l != el || r !== er || f !== ef) begin
                nerr++;
                $display("FAIL random_%0d act=%h a=%h b=%h: got lat=%0d res=%h fl=%b, want lat=%0d res=%h fl=%b",
                         n, act, x, y, l, r, f, el, er, ef);
            end
        end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        active = 16'h0001; a = 8'h12; b = 8'h34; in_valid = 1'b1;
        tick();
        for (int k = 0; k < 5; k++) begin
            active = 16'h0020; a = 8'($urandom); b = 8'($urandom); in_valid = 1'b1;
            nvec++;
            if (out_valid !== 1'b1 || result !== 16'h0046 || flags !== 4'b0000 || in_ready !== 1'b0) begin
                nerr++;
                $display("FAIL stall_%0d: got ov=%0b res=%h fl=%b rdy=%0b, want ov=1 res=0046 fl=0000 rdy=0",
                         k, out_valid, result, flags, in_ready);
            end
            tick();
        end
        out_ready = 1'b1; active = 16'h0010; a = 8'hF0; b = 8'h0F; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        nvec++;
        if (out_valid !== 1'b1 || result !== 16'h00FF || flags !== 4'b0000) begin
            nerr++;
            $display("FAIL stall_release_xor: got ov=%0b res=%h fl=%b, want ov=1 res=00ff fl=0000",
                     out_valid, result, flags);
        end
        tick();
        nvec++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            nerr++;
            $display("FAIL stall_drain: got ov=%0b rdy=%0b, want ov=0 rdy=1", out_valid, in_ready);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] qr[$];
        logic [3:0]  qf[$];
        logic [15:0] er;
        logic [3:0]  ef;
        int l;
        out_ready = 1'b1;
        for (int n = 0; n < 40; n++) begin
            active = gen_act(1'b0); a = 8'($urandom); b = 8'($urandom); in_valid = 1'b1;
            model(active, a, b, er, ef, l);
            qr.push_back(er);
            qf.push_back(ef);
            tick();
            er = qr.pop_front();
            ef = qf.pop_front();
            nvec++;
            if (out_valid !== 1'b1 || in_ready !== 1'b1 || result !== er || flags !== ef) begin
                nerr++;
                $display("FAIL b2b_%0d: got ov=%0b rdy=%0b res=%h fl=%b, want ov=1 rdy=1 res=%h fl=%b",
                         n, out_valid, in_ready, result, flags, er, ef);
            end
        end
        in_valid = 1'b0;
        tick();
        nvec++;
        if (out_valid !== 1'b0) begin
            nerr++;
            $display("FAIL b2b_drain: got ov=%0b, want ov=0", out_valid);
        end
    endtask

    task automatic test_rst_abort();
        int l;
        logic [15:0] r;
        logic [3:0]  f;
        bit seen;
        run_op(16'h0001, 8'h01, 8'h02, l, r, f);
`ifdef ALU_MUL_EN
        active = 16'h0200; a = 8'hFF; b = 8'hFF; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (3) tick();
`else
        out_ready = 1'b0;
        active = 16'h0001; a = 8'h01; b = 8'h02; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
`endif
        rst = 1'b1;
        tick();
        nvec++;
        if (out_valid !== 1'b0 || result !== 16'h0000 || flags !== 4'h0 || in_ready !== 1'b1) begin
            nerr++;
            $display("FAIL rst_abort: got ov=%0b res=%h fl=%b rdy=%0b, want ov=0 res=0000 fl=0000 rdy=1",
                     out_valid, result, flags, in_ready);
        end
        rst = 1'b0; out_ready = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (out_valid) seen = 1'b1;
        end
        nvec++;
        if (seen) begin
            nerr++;
            $display("FAIL rst_no_output: got out_valid after abort, want none");
        end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; active = '0; a = '0; b = '0;
        test_reset();
        test_directed();
        test_mul();
        test_random();
        test_backpressure();
        test_back_to_back();
        test_rst_abort();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
